// File: rtl/rtc_time_parser.sv
// Decodes "T HH:MM:SS <CR|LF>" ASCII frames into a binary time load for the RTC counter.
// Latency: synced/err and new hour/min/sec appear one cycle after the terminator is accepted.
// Backpressure: none; every rx_valid byte is consumed, and stalled frames abort after TIMEOUT_CYC idle cycles.
module rtc_time_parser #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       synced,
  output logic       err,
  output logic       busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIELD = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       tens_q;
  logic [4:0]       hr_stg_q;
  logic [5:0]       mn_stg_q;
  logic [5:0]       sc_stg_q;
  logic             hr_bad_q;
  logic             mn_bad_q;
  logic             sc_bad_q;
  logic [4:0]       hour_q;
  logic [5:0]       min_q;
  logic [5:0]       sec_q;
  logic             synced_q;
  logic             err_q;

  logic       is_t;
  logic       is_digit;
  logic       is_colon;
  logic       is_term;
  logic       byte_ok_d;
  logic       tens_pos_d;
  logic [6:0] field_val_d;

  // Classify the incoming byte and decide whether it fits the current frame position.
  always_comb begin
    is_t        = (rx_data == 8'h54);
    is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_colon    = (rx_data == 8'h3A);
    is_term     = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    byte_ok_d   = 1'b0;
    tens_pos_d  = 1'b0;
    // Full field computed at 7 bits so "99" is range-checked before truncation.
    field_val_d = ({3'b000, tens_q} * 7'd10) + {3'b000, rx_data[3:0]};
    case (idx_q)
      4'd1, 4'd4, 4'd7: begin
        byte_ok_d  = is_digit;
        tens_pos_d = 1'b1;
      end
      4'd2, 4'd5, 4'd8: byte_ok_d = is_digit;
      4'd3, 4'd6:       byte_ok_d = is_colon;
      4'd9:             byte_ok_d = is_term;
      default:          byte_ok_d = 1'b0;
    endcase
  end

  // Frame state machine with staging registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      cnt_q    <= '0;
      tens_q   <= 4'd0;
      hr_stg_q <= 5'd0;
      mn_stg_q <= 6'd0;
      sc_stg_q <= 6'd0;
      hr_bad_q <= 1'b0;
      mn_bad_q <= 1'b0;
      sc_bad_q <= 1'b0;
      hour_q   <= 5'd0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      synced_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      synced_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_FIELD: begin
          if (rx_valid) begin
            cnt_q <= '0;
            if (byte_ok_d) begin
              idx_q <= idx_q + 4'd1;
              if (idx_q == 4'd9) begin
                state_q <= S_CHECK;
              end else if (tens_pos_d) begin
                tens_q <= rx_data[3:0];
              end else if (idx_q == 4'd2) begin
                hr_stg_q <= field_val_d[4:0];
                hr_bad_q <= (field_val_d > 7'd23);
              end else if (idx_q == 4'd5) begin
                mn_stg_q <= field_val_d[5:0];
                mn_bad_q <= (field_val_d > 7'd59);
              end else if (idx_q == 4'd8) begin
                sc_stg_q <= field_val_d[5:0];
                sc_bad_q <= (field_val_d > 7'd59);
              end
            end else begin
              // A stray 'T' is taken as the start of a fresh frame.
              err_q <= 1'b1;
              if (is_t) begin
                idx_q <= 4'd1;
              end else begin
                state_q <= S_IDLE;
                idx_q   <= 4'd0;
              end
            end
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE and CHECK both listen for a new 'T', so frames can run back-to-back.
          if (state_q == S_CHECK) begin
            if (!hr_bad_q && !mn_bad_q && !sc_bad_q) begin
              hour_q   <= hr_stg_q;
              min_q    <= mn_stg_q;
              sec_q    <= sc_stg_q;
              synced_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (rx_valid && is_t) begin
            state_q <= S_FIELD;
            idx_q   <= 4'd1;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign hour   = hour_q;
  assign min    = min_q;
  assign sec    = sec_q;
  assign synced = synced_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_time_parser.sv
// Bench for rtc_time_parser: directed ASCII frames checked against a byte-buffer model every cycle.
// Latency: model predicts outputs one cycle after the sampling edge, matching registered strobes.
// Backpressure: none; the bench drives bytes freely with chosen gaps.
module tb_rtc_time_parser;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       synced;
  logic       err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Pulse/observation counters, updated only by the compare process.
  int sync_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;

  rtc_time_parser #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .hour(hour), .min(min), .sec(sec), .synced(synced), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] fq[$];     // bytes of the frame collected so far
  int         idle_gap;  // quiet cycles since last byte inside a frame
  bit         pend;      // complete frame awaiting its verdict
  int         ph, pm, ps;
  int         e_hour, e_min, e_sec;
  bit         e_sync, e_err, e_busy;

  function automatic bit fits(int pos, logic [7:0] b);
    if (pos == 3 || pos == 6) return b == 8'h3A;
    if (pos == 9) return (b == 8'h0D) || (b == 8'h0A);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  task automatic model_step();
    if (rst) begin
      fq.delete(); idle_gap = 0; pend = 0;
      e_hour = 0; e_min = 0; e_sec = 0; e_sync = 0; e_err = 0; e_busy = 0;
      return;
    end
    e_sync = 0; e_err = 0;
    if (pend) begin
      pend = 0;
      if (ph <= 23 && pm <= 59 && ps <= 59) begin
        e_hour = ph; e_min = pm; e_sec = ps; e_sync = 1;
      end else begin
        e_err = 1;
      end
    end
    if (fq.size() > 0) begin
      if (rx_valid) begin
        idle_gap = 0;
        if (fits(fq.size(), rx_data)) begin
          fq.push_back(rx_data);
          if (fq.size() == 10) begin
            ph = (int'(fq[1]) - 48) * 10 + (int'(fq[2]) - 48);
            pm = (int'(fq[4]) - 48) * 10 + (int'(fq[5]) - 48);
            ps = (int'(fq[7]) - 48) * 10 + (int'(fq[8]) - 48);
            pend = 1;
            fq.delete();
          end
        end else begin
          e_err = 1;
          fq.delete();
          if (rx_data == 8'h54) fq.push_back(rx_data);
        end
      end else begin
        idle_gap++;
        if (idle_gap == TO) begin
          e_err = 1;
          fq.delete();
        end
      end
    end else if (rx_valid && rx_data == 8'h54) begin
      fq.push_back(rx_data);
      idle_gap = 0;
    end
    e_busy = (fq.size() > 0) || pend;
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      checks++;
      if (hour !== 5'(e_hour) || min !== 6'(e_min) || sec !== 6'(e_sec) ||
          synced !== e_sync || err !== e_err || busy !== e_busy) begin
        failures++;
        $display("FAIL cycle_model t=%0t got h=%0d m=%0d s=%0d sync=%b err=%b busy=%b want h=%0d m=%0d s=%0d sync=%b err=%b busy=%b",
                 $time, hour, min, sec, synced, err, busy,
                 e_hour, e_min, e_sec, e_sync, e_err, e_busy);
      end
      if (synced === 1'b1) sync_cnt++;
      if (err === 1'b1) err_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Each byte is driven on consecutive negedges when gap is 0 (back-to-back).
  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int s0, e0, b0;

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("reset_hour", int'(hour), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_synced", int'(synced), 0);

    // valid frame, back-to-back bytes
    s0 = sync_cnt; e0 = err_cnt;
    send_str("T10:20:30", 0); send_byte(8'h0D, 3);
    chk("valid_hour", int'(hour), 10);
    chk("valid_min", int'(min), 20);
    chk("valid_sec", int'(sec), 30);
    chk("valid_sync_pulses", sync_cnt - s0, 1);
    chk("valid_err_pulses", err_cnt - e0, 0);

    // hour out of range
    s0 = sync_cnt; e0 = err_cnt;
    send_str("T24:00:00", 0); send_byte(8'h0A, 3);
    chk("oor_hour_err", err_cnt - e0, 1);
    chk("oor_hour_nosync", sync_cnt - s0, 0);
    chk("oor_hour_hold", int'(hour), 10);
    chk("oor_hour_hold_sec", int'(sec), 30);

    // minute out of range (60)
    e0 = err_cnt;
    send_str("T00:60:00", 0); send_byte(8'h0A, 3);
    chk("oor_min_err", err_cnt - e0, 1);
    chk("oor_min_hold", int'(min), 20);

    // bad character
    e0 = err_cnt;
    send_str("T1A", 0); idle(2);
    chk("badchar_err", err_cnt - e0, 1);
    chk("badchar_busy", int'(busy), 0);

    // mid-frame T restarts the frame
    s0 = sync_cnt; e0 = err_cnt;
    send_str("T12:T23:59:59", 0); send_byte(8'h0A, 3);
    chk("restart_err", err_cnt - e0, 1);
    chk("restart_sync", sync_cnt - s0, 1);
    chk("restart_hour", int'(hour), 23);
    chk("restart_min", int'(min), 59);
    chk("restart_sec", int'(sec), 59);

    // timeout
    e0 = err_cnt;
    send_str("T12", 0); idle(TO + 3);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_busy", int'(busy), 0);

    // slow frame with 5-cycle gaps
    s0 = sync_cnt; e0 = err_cnt;
    send_str("T01:02:03", 5); send_byte(8'h0A, 3);
    chk("gap_sync", sync_cnt - s0, 1);
    chk("gap_err", err_cnt - e0, 0);
    chk("gap_hour", int'(hour), 1);
    chk("gap_min", int'(min), 2);
    chk("gap_sec", int'(sec), 3);

    // back-to-back frames with zero gap
    s0 = sync_cnt;
    send_str("T01:01:01", 0); rx_data = 8'h0D;
    send_str("\nT02:02:02", 0); send_byte(8'h0D, 3);
    chk("b2b_sync", sync_cnt - s0, 2);
    chk("b2b_sec", int'(sec), 2);

    // reset mid-frame
    send_str("T10:20:30", 0); send_byte(8'h0D, 2);
    e0 = err_cnt;
    send_str("T05:0", 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    idle(2);
    chk("rst_err", err_cnt - e0, 0);
    chk("rst_hour", int'(hour), 0);
    chk("rst_busy", int'(busy), 0);
    send_str("T05:06:07", 0); send_byte(8'h0A, 3);
    chk("after_rst_hour", int'(hour), 5);
    chk("after_rst_min", int'(min), 6);
    chk("after_rst_sec", int'(sec), 7);

    // noise in IDLE
    s0 = sync_cnt; e0 = err_cnt; b0 = busy_cnt;
    send_str("xyz\n", 0); idle(3);
    chk("noise_err", err_cnt - e0, 0);
    chk("noise_sync", sync_cnt - s0, 0);
    chk("noise_busy", busy_cnt - b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
